// File: rtl/bsg_print_stat_event_buffer_pkg.sv
// bsg_print_stat_pkg: kind/state enums and record-width helper; BSG_PRINT_STAT_DURATION_EN adds the duration field
package bsg_print_stat_pkg;

    localparam int kind_width_lp = 2;

    typedef enum logic [1:0] {STAT = 2'b00, START = 2'b01, END = 2'b10, RSVD = 2'b11} kind_e;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

`ifdef BSG_PRINT_STAT_DURATION_EN
    localparam bit duration_en_lp = 1'b1;
`else
    localparam bit duration_en_lp = 1'b0;
`endif

    function automatic int record_width(int data_width, int ctr_width, bit duration_en);
        return kind_width_lp + data_width + ctr_width + (duration_en ? ctr_width : 0);
    endfunction

endpackage

// File: rtl/bsg_print_stat_event_buffer_if.sv
// bsg_print_stat_event_buffer_if: event input, record output and status signals of the event buffer
interface bsg_print_stat_event_buffer_if #(
    parameter int data_width_p = 32,
    parameter int ctr_width_p  = 64
);
    import bsg_print_stat_pkg::*;

    localparam int record_width_lp = record_width(data_width_p, ctr_width_p, duration_en_lp);

    logic                       print_stat_v_i;
    logic [data_width_p-1:0]    print_stat_tag_i;
    logic [ctr_width_p-1:0]     global_ctr_i;
    logic                       v_o;
    logic [record_width_lp-1:0] data_o;
    logic                       yumi_i;
    logic [31:0]                drop_count_o;
    logic                       active_o;

    modport master (
        output print_stat_v_i, print_stat_tag_i, global_ctr_i, yumi_i,
        input  v_o, data_o, drop_count_o, active_o
    );

    modport slave (
        input  print_stat_v_i, print_stat_tag_i, global_ctr_i, yumi_i,
        output v_o, data_o, drop_count_o, active_o
    );

endinterface

// File: rtl/bsg_print_stat_event_buffer_fifo.sv
// bsg_fifo_1r1w_small: power-of-2 depth FIFO with registered storage; accepts a write when full if the head is taken the same cycle
module bsg_fifo_1r1w_small #(
    parameter int els_p   = 16,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] wptr, rptr;
    logic [ptr_w_lp:0]   count;
    logic                enq, deq;

    assign v_o     = count != '0;
    assign ready_o = (count != (ptr_w_lp+1)'(els_p)) | yumi_i;
    assign enq     = v_i & ready_o & ~reset_i;
    assign deq     = yumi_i & v_o & ~reset_i;
    assign data_o  = mem[rptr];

    // storage write at the tail
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

    // pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            count <= count + (ptr_w_lp+1)'(enq) - (ptr_w_lp+1)'(deq);
        end
    end

endmodule

// File: rtl/bsg_print_stat_event_buffer.sv
// bsg_print_stat_event_buffer: timestamps print-stat events into a FIFO, tracks kernel intervals; BSG_PRINT_STAT_DURATION_EN adds END durations
module bsg_print_stat_event_buffer
    import bsg_print_stat_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int ctr_width_p  = 64,
    parameter int els_p        = 16
) (
    input logic clk_i,
    input logic reset_i,
    bsg_print_stat_event_buffer_if.slave bus
);

    localparam int record_width_lp = record_width(data_width_p, ctr_width_p, duration_en_lp);

    kind_e                      kind;
    state_e                     state;
    logic                       active;
    logic                       enq_ready;
    logic                       drop;
    logic [31:0]                drop_count;
    logic [record_width_lp-1:0] record;

    assign kind = kind_e'(bus.print_stat_tag_i[data_width_p-1 -: kind_width_lp]);
    assign drop = bus.print_stat_v_i & ~enq_ready;

`ifdef BSG_PRINT_STAT_DURATION_EN
    logic [ctr_width_p-1:0] start_ts;
    logic [ctr_width_p-1:0] duration;

    assign duration = (state == ACTIVE && kind == END) ? bus.global_ctr_i - start_ts : '0;
    assign record   = {kind, bus.print_stat_tag_i, bus.global_ctr_i, duration};

    // latch the timestamp of every START, including re-STARTs while active
    always_ff @(posedge clk_i) begin
        if (reset_i) start_ts <= '0;
        else if (bus.print_stat_v_i && kind == START) start_ts <= bus.global_ctr_i;
    end
`else
    assign record = {kind, bus.print_stat_tag_i, bus.global_ctr_i};
`endif

    // interval FSM; advances on every event, dropped or not
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            active <= 1'b0;
        end else if (bus.print_stat_v_i && kind == START) begin
            state  <= ACTIVE;
            active <= 1'b1;
        end else if (bus.print_stat_v_i && kind == END) begin
            state  <= IDLE;
            active <= 1'b0;
        end
    end

    // saturating count of events lost to a full FIFO
    always_ff @(posedge clk_i) begin
        if (reset_i) drop_count <= '0;
        else if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end

    assign bus.active_o     = active;
    assign bus.drop_count_o = drop_count;

    bsg_fifo_1r1w_small #(
        .els_p  (els_p),
        .width_p(record_width_lp)
    ) fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (bus.print_stat_v_i),
        .data_i (record),
        .ready_o(enq_ready),
        .v_o    (bus.v_o),
        .data_o (bus.data_o),
        .yumi_i (bus.yumi_i)
    );

endmodule

// File: tb/tb_bsg_print_stat_event_buffer.sv
// tb_bsg_print_stat_event_buffer: table-driven and sequence checks of the print-stat event buffer
module tb_bsg_print_stat_event_buffer;
    import bsg_print_stat_pkg::*;

    localparam int rw = record_width(32, 64, duration_en_lp);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bsg_print_stat_event_buffer_if #(.data_width_p(32), .ctr_width_p(64)) bus ();

    bsg_print_stat_event_buffer #(.data_width_p(32), .ctr_width_p(64), .els_p(16)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    typedef struct {
        logic        v;
        logic [1:0]  k;
        logic [29:0] p;
        logic [63:0] ctr;
        logic        yumi;
        logic        ev;
        logic [1:0]  ek;
        logic [29:0] ep;
        logic [63:0] ets;
        logic [63:0] edur;
        logic        eact;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [rw-1:0] mk(input logic [1:0] k, input logic [29:0] p,
                                         input logic [63:0] ts, input logic [63:0] dur);
        logic [161:0] f;
        f = {k, k, p, ts, dur};
        return rw'(f >> (162 - rw));
    endfunction

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [29:0] p,
                         input logic [63:0] ctr, input logic yumi);
        bus.print_stat_v_i   = v;
        bus.print_stat_tag_i = {k, p};
        bus.global_ctr_i     = ctr;
        bus.yumi_i           = yumi;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, START, 30'd10, 64'd100, 1'b0, 1'b1, START, 30'd10, 64'd100, 64'd0,   1'b1};
        vecs[1]  = '{1'b0, STAT,  30'd0,  64'd101, 1'b1, 1'b0, STAT,  30'd0,  64'd0,   64'd0,   1'b1};
        vecs[2]  = '{1'b0, STAT,  30'd0,  64'd102, 1'b0, 1'b0, STAT,  30'd0,  64'd0,   64'd0,   1'b1};
        vecs[3]  = '{1'b1, END,   30'd11, 64'd350, 1'b0, 1'b1, END,   30'd11, 64'd350, 64'd250, 1'b0};
        vecs[4]  = '{1'b0, STAT,  30'd0,  64'd351, 1'b1, 1'b0, STAT,  30'd0,  64'd0,   64'd0,   1'b0};
        vecs[5]  = '{1'b1, STAT,  30'd5,  64'd400, 1'b0, 1'b1, STAT,  30'd5,  64'd400, 64'd0,   1'b0};
        vecs[6]  = '{1'b1, RSVD,  30'd6,  64'd401, 1'b1, 1'b1, RSVD,  30'd6,  64'd401, 64'd0,   1'b0};
        vecs[7]  = '{1'b1, END,   30'd7,  64'd402, 1'b1, 1'b1, END,   30'd7,  64'd402, 64'd0,   1'b0};
        vecs[8]  = '{1'b1, START, 30'd8,  64'd500, 1'b1, 1'b1, START, 30'd8,  64'd500, 64'd0,   1'b1};
        vecs[9]  = '{1'b1, START, 30'd9,  64'd600, 1'b1, 1'b1, START, 30'd9,  64'd600, 64'd0,   1'b1};
        vecs[10] = '{1'b1, STAT,  30'd10, 64'd650, 1'b1, 1'b1, STAT,  30'd10, 64'd650, 64'd0,   1'b1};
        vecs[11] = '{1'b1, END,   30'd11, 64'd700, 1'b1, 1'b1, END,   30'd11, 64'd700, 64'd100, 1'b0};
        vecs[12] = '{1'b0, STAT,  30'd0,  64'd701, 1'b1, 1'b0, STAT,  30'd0,  64'd0,   64'd0,   1'b0};
        vecs[13] = '{1'b1, START, 30'd13, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 1'b1, START, 30'd13, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 1'b1};
        vecs[14] = '{1'b1, END,   30'd14, 64'd5,   1'b1, 1'b1, END,   30'd14, 64'd5,   64'd15,  1'b0};
        vecs[15] = '{1'b0, STAT,  30'd0,  64'd6,   1'b1, 1'b0, STAT,  30'd0,  64'd0,   64'd0,   1'b0};

        rst = 1'b1;
        drive(1'b1, START, 30'd1, 64'd1, 1'b0);
        tick();
        tick();
        chk("reset_v", bus.v_o, 1'b0);
        chk("reset_drop", bus.drop_count_o, 32'd0);
        chk("reset_active", bus.active_o, 1'b0);
        rst = 1'b0;
        drive(1'b0, STAT, 30'd0, 64'd0, 1'b0);
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].k, vecs[i].p, vecs[i].ctr, vecs[i].yumi);
            tick();
            chk($sformatf("vec%0d_v", i), bus.v_o, vecs[i].ev);
            if (vecs[i].ev)
                chk($sformatf("vec%0d_data", i), bus.data_o,
                    mk(vecs[i].ek, vecs[i].ep, vecs[i].ets, vecs[i].edur));
            chk($sformatf("vec%0d_drop", i), bus.drop_count_o, 32'd0);
            chk($sformatf("vec%0d_active", i), bus.active_o, vecs[i].eact);
        end

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, STAT, 30'(i), 64'(1000 + i), 1'b0);
            tick();
            chk($sformatf("fill%0d_drop", i), bus.drop_count_o, 32'(i < 16 ? 0 : i - 15));
        end
        chk("full_head", bus.data_o, mk(STAT, 30'd0, 64'd1000, 64'd0));

        drive(1'b1, START, 30'd0, 64'd1500, 1'b0);
        tick();
        chk("dropped_start_drop", bus.drop_count_o, 32'd5);
        chk("dropped_start_active", bus.active_o, 1'b1);
        drive(1'b1, END, 30'd0, 64'd1600, 1'b0);
        tick();
        chk("dropped_end_drop", bus.drop_count_o, 32'd6);
        chk("dropped_end_active", bus.active_o, 1'b0);

        drive(1'b1, STAT, 30'd99, 64'd2000, 1'b1);
        tick();
        chk("simul_drop", bus.drop_count_o, 32'd6);

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_v", i), bus.v_o, 1'b1);
            chk($sformatf("drain%0d_data", i), bus.data_o,
                i < 15 ? mk(STAT, 30'(i + 1), 64'(1001 + i), 64'd0) : mk(STAT, 30'd99, 64'd2000, 64'd0));
            drive(1'b0, STAT, 30'd0, 64'd2100, 1'b1);
            tick();
        end
        chk("drained_v", bus.v_o, 1'b0);

        drive(1'b1, START, 30'd1, 64'd3000, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, STAT, 30'(i), 64'(3001 + i), 1'b0);
            tick();
        end
        chk("pre_reset_active", bus.active_o, 1'b1);
        chk("pre_reset_drop", bus.drop_count_o, 32'd6);
        rst = 1'b1;
        drive(1'b1, STAT, 30'd0, 64'd3005, 1'b0);
        tick();
        chk("midreset_v", bus.v_o, 1'b0);
        chk("midreset_drop", bus.drop_count_o, 32'd0);
        chk("midreset_active", bus.active_o, 1'b0);
        rst = 1'b0;
        drive(1'b0, STAT, 30'd0, 64'd3006, 1'b0);
        tick();
        chk("post_reset_v", bus.v_o, 1'b0);

        drive(1'b1, END, 30'd2, 64'd3100, 1'b0);
        tick();
        chk("idle_end_v", bus.v_o, 1'b1);
        chk("idle_end_data", bus.data_o, mk(END, 30'd2, 64'd3100, 64'd0));
        chk("idle_end_active", bus.active_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_print_stat_event_buffer.md
BSG_PRINT_STAT_EVENT_BUFFER -- requirements
Module: bsg_print_stat_event_buffer

Interface
REQ-001 The block SHALL have parameter data_width_p, default 32, giving the print-stat tag width.
REQ-002 The block SHALL have parameter ctr_width_p, default 64, giving the global cycle counter width.
REQ-003 The block SHALL have parameter els_p, default 16, giving the record FIFO depth; it is a power of 2 and at least 2.
REQ-004 Port clk_i, input, 1 bit: the only clock, the core clock.
REQ-005 Port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port print_stat_v_i, input, 1 bit: print-stat event strobe from the print-stat snoop.
REQ-007 Port print_stat_tag_i, input, data_width_p bits: the event tag.
REQ-008 Port global_ctr_i, input, ctr_width_p bits: free-running cycle counter used as the timestamp.
REQ-009 Port v_o, output, 1 bit: a record is available at the FIFO head.
REQ-010 Port data_o, output, record_width bits: the head record.
REQ-011 Port yumi_i, input, 1 bit: consumer takes the head record; legal only while v_o=1.
REQ-012 Port drop_count_o, output, 32 bits: number of events dropped because the FIFO was full.
REQ-013 Port active_o, output, 1 bit: a kernel interval is open.

Function
REQ-014 Kind SHALL be decoded from print_stat_tag_i[data_width_p-1 -: 2]:
  - 00 = STAT
  - 01 = START
  - 10 = END
  - 11 = RSVD
REQ-015 The record SHALL be the concatenation, MSB first, of {kind[1:0], tag[data_width_p], timestamp[ctr_width_p], duration[ctr_width_p]}.
REQ-016 The timestamp SHALL be the value of global_ctr_i in the cycle print_stat_v_i=1.
REQ-017 Latency: an event accepted in cycle N SHALL appear on v_o/data_o no earlier than cycle N+1, and exactly at N+1 if the FIFO was empty.
REQ-018 The FIFO SHALL be first-in first-out with a registered head; data_o SHALL hold steady while v_o=1 and yumi_i=0.
REQ-019 Full FIFO, event arrives, yumi_i=0: the event SHALL be dropped and drop_count_o incremented, saturating at 32'hFFFF_FFFF.
REQ-020 Full FIFO, event arrives, yumi_i=1 in the same cycle: the event SHALL be accepted and nothing dropped.
REQ-021 Empty FIFO, event arrives: the event SHALL be enqueued; it is not bypassed combinationally to v_o.
REQ-022 The interval FSM SHALL have two states, IDLE and ACTIVE; active_o=1 exactly in ACTIVE.
REQ-023 START in IDLE SHALL move to ACTIVE and latch start_ts = timestamp.
REQ-024 START in ACTIVE SHALL stay ACTIVE and re-latch start_ts.
REQ-025 END in ACTIVE SHALL move to IDLE.
REQ-026 END in IDLE SHALL stay IDLE.
REQ-027 STAT and RSVD events SHALL NOT change FSM state.
REQ-028 FSM transitions SHALL occur even when the event itself is dropped.
REQ-029 Duration: END in ACTIVE SHALL carry (timestamp - start_ts) mod 2^ctr_width_p, so counter wrap is handled; every other record SHALL carry duration 0.

Reset
REQ-030 While reset_i=1:
  - FIFO emptied, v_o=0
  - drop_count_o=0
  - FSM=IDLE, active_o=0
  - start_ts=0
  - print_stat_v_i and yumi_i ignored
REQ-031 A reset asserted mid-operation SHALL discard all buffered records in the next cycle; data_o is don't-care while v_o=0.

Configuration
REQ-032 With macro BSG_PRINT_STAT_DURATION_EN defined, duration SHALL be computed per REQ-029.
REQ-033 Without BSG_PRINT_STAT_DURATION_EN:
  - the duration field SHALL be removed, so record_width = 2 + data_width_p + ctr_width_p
  - the start_ts register SHALL not exist
  - the FSM and active_o SHALL be retained

Structure
REQ-034 Package bsg_print_stat_pkg SHALL hold:
  - the kind enum (STAT/START/END/RSVD)
  - the kind field width (2)
  - a record-width function of (data_width_p, ctr_width_p, duration enable)
REQ-035 The FIFO SHALL be one sub-module instance, bsg_fifo_1r1w_small (els_p, record_width); the FSM, drop counter and record packing SHALL stay in this module.

Verification
REQ-036 Check START/END timing: after reset, START at ctr=100 and END at ctr=350, consumer always takes records:
  - records {START,tag,100,0} then {END,tag,350,250}
  - active_o=1 for the cycles between the two events
REQ-037 Check full-FIFO drops with els_p=16: 20 STAT events on consecutive cycles with yumi_i=0 give 16 records held and drop_count_o=4; then draining gives records in order, timestamps strictly increasing.
REQ-038 Check simultaneous accept and dequeue: with the FIFO full, one event arrives with yumi_i=1 in the same cycle; drop_count_o is unchanged and occupancy stays 16.
REQ-039 Check counter wrap: START at ctr=2^64-10 and END at ctr=5 give END duration 15.
REQ-040 Check unmatched END and mid-run reset:
  - END in IDLE gives duration 0 and active_o stays 0
  - reset_i pulsed with 5 records buffered gives v_o=0 and drop_count_o=0 on the next cycle
REQ-041 Check the build without the macro: without BSG_PRINT_STAT_DURATION_EN, data_o width is 2+32+64=98 and START/END ordering is unchanged.
